// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared widths, divider latency and sequencer state encoding.
package div_sequencer_pkg;
  localparam int DATA_W = 32;
  localparam int DIV_LAT = 32;
  localparam int CNT_W = $clog2(DIV_LAT) + 1;
  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_e;
endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: control-unit side of the divide sequencer (request, HI/LO access, status).
interface div_sequencer_if;
  import div_sequencer_pkg::*;
  logic start;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic hi_we;
  logic lo_we;
  logic [DATA_W-1:0] hilo_wdata;
  logic busy;
  logic done;
  logic div_zero;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  modport master(output start, a_in, b_in, hi_we, lo_we, hilo_wdata,
                 input busy, done, div_zero, hi_out, lo_out);
  modport slave(input start, a_in, b_in, hi_we, lo_we, hilo_wdata,
                output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/div_sequencer_hilo_regs.sv
// hilo_regs: architectural HI/LO with an mthi/mtlo port (blocked while busy) and a capture port.
module hilo_regs
  import div_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              busy,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cap_we,
  input  logic [DATA_W-1:0] cap_hi,
  input  logic [DATA_W-1:0] cap_lo,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  always_comb begin
    hi_d = cap_we ? cap_hi : (hi_we && !busy) ? wdata : hi_q;
    lo_d = cap_we ? cap_lo : (lo_we && !busy) ? wdata : lo_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: runs the iterative signed divider for DIV_LAT enabled cycles and captures HI/LO.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  div_sequencer_if.slave    bus,
  output logic              div_ctrl,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic [DATA_W-1:0] div_quociente,
  input  logic [DATA_W-1:0] div_resto,
  input  logic              div_divq
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic done_q, done_d, dz_q, dz_d, cap;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    cap = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d = bus.a_in;
        b_d = bus.b_in;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_divq) begin
          state_d = IDLE;
          done_d = 1'b1;
          dz_d = 1'b1;
        end else if (cnt_q == CNT_W'(DIV_LAT - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        cap = 1'b1;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  // div_ctrl stays high through CAPTURE so the divider holds its results while they are sampled
  assign div_ctrl = (state_q == RUN) || (state_q == CAPTURE);
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.div_zero = dz_q;
  assign div_a = a_q;
  assign div_b = b_q;
  hilo_regs u_hilo (
    .clk(clk),
    .reset(reset),
    .busy(bus.busy),
    .hi_we(bus.hi_we),
    .lo_we(bus.lo_we),
    .wdata(bus.hilo_wdata),
    .cap_we(cap),
    .cap_hi(div_resto),
    .cap_lo(div_quociente),
    .hi_out(bus.hi_out),
    .lo_out(bus.lo_out)
  );
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed divides against a behavioural divider, scoreboarded on done.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  div_sequencer_if bus();
  logic div_ctrl, div_divq = 1'b0;
  logic [31:0] div_a, div_b, div_q, div_r;
  div_sequencer dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .div_ctrl(div_ctrl),
    .div_a(div_a),
    .div_b(div_b),
    .div_quociente(div_q),
    .div_resto(div_r),
    .div_divq(div_divq)
  );
  // behavioural divider: clears whenever div_ctrl is low, results valid after 32 enabled edges
  int dcnt = 0;
  always @(posedge clk) begin
    if (!div_ctrl) begin
      dcnt <= 0;
      div_divq <= 1'b0;
    end else begin
      dcnt <= dcnt + 1;
      div_divq <= (div_b == 32'd0);
    end
  end
  always_comb begin
    div_q = 32'hDEADBEEF;
    div_r = 32'hDEADBEEF;
    if (dcnt >= 32 && div_b != 32'd0) begin
      div_q = $signed(div_a) / $signed(div_b);
      div_r = $signed(div_a) % $signed(div_b);
    end
  end
  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic dz;
    int due;
  } exp_t;
  exp_t sb[$];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", pcnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("lo_out", bus.lo_out, e.lo);
        chk("hi_out", bus.hi_out, e.hi);
        chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
        chk("done_latency", pcnt, e.due);
      end
    end
  end
  // called at a negedge; the next posedge is the start edge
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] elo,
                          input logic [31:0] ehi, input logic edz, input int lat, input bit push);
    exp_t e;
    bus.a_in = a;
    bus.b_in = b;
    bus.start = 1'b1;
    e.lo = elo;
    e.hi = ehi;
    e.dz = edz;
    e.due = pcnt + lat + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in = 32'h13579BDF;
    bus.b_in = 32'h0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending %0d", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.start = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.hilo_wdata = '0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("rst_div_ctrl", {31'd0, div_ctrl}, 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_hi", bus.hi_out, 32'd0);
    chk("rst_lo", bus.lo_out, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 32'd33);
    wait_done();
    do_start(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, 1'b1);
    n = 0;
    while (div_ctrl && n < 100) begin
      if (n == 5) begin
        chk("div_a_hold", div_a, 32'hFFFFFFF9);
        chk("div_b_hold", div_b, 32'd2);
      end
      n++;
      @(negedge clk);
    end
    chk("div_ctrl_cycles", n, 32'd33);
    wait_done();
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.hilo_wdata = 32'h1234;
    @(negedge clk);
    chk("mthilo_hi", bus.hi_out, 32'h1234);
    chk("mthilo_lo", bus.lo_out, 32'h1234);
    bus.lo_we = 1'b0;
    bus.hilo_wdata = 32'hAAAA;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.hilo_wdata = 32'h5555;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("preload_hi", bus.hi_out, 32'hAAAA);
    chk("preload_lo", bus.lo_out, 32'h5555);
    do_start(32'd5, 32'd0, 32'h5555, 32'hAAAA, 1'b1, 2, 1'b1);
    wait_done();
    chk("dz_busy_after", {31'd0, bus.busy}, 32'd0);
    do_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.a_in = 32'd1;
    bus.b_in = 32'd1;
    bus.hi_we = 1'b1;
    bus.hilo_wdata = 32'hBAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk("hi_we_while_busy", bus.hi_out, 32'hAAAA);
    wait_done();
    repeat (40) @(negedge clk);
    do_start(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 33, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_div_ctrl", {31'd0, div_ctrl}, 32'd0);
    chk("abort_hi", bus.hi_out, 32'd0);
    chk("abort_lo", bus.lo_out, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    do_start(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 1'b1);
    wait_done();
    do_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    repeat (33) @(negedge clk);
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    do_start(32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, 33, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
